// File: rtl/port_host.sv
// Host-side driver for the 16-bit I/O port: queues host words into timed port_write strobes
// and reports port_out changes back through a valid/ack register. Optional: PORT_HOST_OVERRUN_EN.
module port_host #(
    parameter int DEPTH = 4,
    parameter int PULSE = 10,
    parameter int GAP   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [15:0] push_data,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        port_write,
    output logic [15:0] port_in,
    input  logic [15:0] port_out,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ack
`ifdef PORT_HOST_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (PULSE > GAP) ? PULSE : GAP;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP == 0) ? '0 : CW'(GAP - 1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          pw_next;
    logic          pop;
    logic          push_ok;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;

    logic [15:0]   prev_out;
    logic          change;

    // full is the registered flag, so a push on full is dropped even if a pop happens this edge
    assign push_ok = push && !full;
    assign busy    = (state != S_IDLE);
    assign change  = (port_out != prev_out);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pw_next    = port_write;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    pw_next    = 1'b1;
                    cnt_next   = PULSE_LOAD;
                    state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    pw_next = 1'b0;
                    if (GAP == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        cnt_next   = GAP_LOAD;
                        state_next = S_GAP;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (!push_ok && pop) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            port_write <= 1'b0;
            port_in    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            port_write <= pw_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                port_in <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
        end
    end

    // A fresh change always wins over a same-edge acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_out  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            prev_out <= port_out;
            if (change) begin
                out_valid <= 1'b1;
                out_data  <= port_out;
            end else if (out_ack) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PORT_HOST_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (change && out_valid && !out_ack) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_port_host.sv
// Randomised bench for port_host: a queue/timer reference model compared every cycle,
// plus literal expectations for strobe timing, FIFO limits, monitor and reset behaviour.
module tb_port_host;

    localparam int DEPTH = 4;
    localparam int PULSE = 10;
    localparam int GAP   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0;
    logic [15:0] push_data = '0;
    logic        full, empty, busy, port_write;
    logic [15:0] port_in;
    logic [15:0] port_out = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ack = 1'b0;

    logic        push2 = 1'b0;
    logic [15:0] push_data2 = '0;
    logic        full2, empty2, busy2, port_write2, out_valid2;
    logic [15:0] port_in2, out_data2;

`ifdef PORT_HOST_OVERRUN_EN
    logic overrun, overrun2;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    port_host #(.DEPTH(DEPTH), .PULSE(PULSE), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .full(full), .empty(empty), .busy(busy), .port_write(port_write),
        .port_in(port_in), .port_out(port_out), .out_valid(out_valid),
        .out_data(out_data), .out_ack(out_ack)
`ifdef PORT_HOST_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    port_host #(.DEPTH(2), .PULSE(3), .GAP(0)) u_gap0 (
        .clk(clk), .reset(reset), .push(push2), .push_data(push_data2),
        .full(full2), .empty(empty2), .busy(busy2), .port_write(port_write2),
        .port_in(port_in2), .port_out(16'd0), .out_valid(out_valid2),
        .out_data(out_data2), .out_ack(1'b0)
`ifdef PORT_HOST_OVERRUN_EN
        , .overrun(overrun2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: FIFO as a bounded queue, transmitter as a time-since-pop counter
    logic [15:0] m_q[$];
    bit          m_busy;
    int          m_t;
    logic [15:0] m_pin, m_prev, m_data;
    bit          m_valid, m_ovr;
    bit          model_ok = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_q.delete();
            m_busy = 0; m_t = 0; m_pin = '0; m_prev = '0;
            m_valid = 0; m_data = '0; m_ovr = 0;
            model_ok = 1;
        end else begin : upd
            bit pop, pok;
            pop = !m_busy && (m_q.size() > 0);
            pok = push && (m_q.size() < DEPTH);
            if (pop) begin
                m_pin = m_q.pop_front();
                m_busy = 1;
                m_t = 0;
            end else if (m_busy) begin
                m_t++;
                if (m_t == PULSE + GAP) m_busy = 0;
            end
            if (pok) m_q.push_back(push_data);
            if (port_out != m_prev) begin
                if (m_valid && !out_ack) m_ovr = 1;
                m_data = port_out;
                m_valid = 1;
            end else if (out_ack) begin
                m_valid = 0;
            end
            m_prev = port_out;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("full", full, m_q.size() == DEPTH);
            chk("empty", empty, m_q.size() == 0);
            chk("busy", busy, m_busy);
            chk("port_write", port_write, m_busy && (m_t < PULSE));
            chk("port_in", port_in, m_pin);
            chk("out_valid", out_valid, m_valid);
            chk("out_data", out_data, m_data);
`ifdef PORT_HOST_OVERRUN_EN
            chk("overrun", overrun, m_ovr);
`endif
        end
    end

    // Strobe recorder: rise cycle, data at rise, and high length of each pulse
    int          rise_t[$], plen[$], rise2_t[$];
    logic [15:0] rise_d[$], rise2_d[$];
    logic        pw_q = 0, pw2_q = 0;
    int          cur_len = 0;

    always @(negedge clk) begin
        if (port_write === 1'b1 && pw_q !== 1'b1) begin
            rise_t.push_back(cyc);
            rise_d.push_back(port_in);
            cur_len = 0;
        end
        if (port_write === 1'b1) cur_len++;
        if (port_write !== 1'b1 && pw_q === 1'b1) plen.push_back(cur_len);
        pw_q = port_write;
        if (port_write2 === 1'b1 && pw2_q !== 1'b1) begin
            rise2_t.push_back(cyc);
            rise2_d.push_back(port_in2);
        end
        pw2_q = port_write2;
    end

    function automatic void clear_rec();
        rise_t.delete(); rise_d.delete(); plen.delete();
    endfunction

    initial begin
        int n;
        logic [15:0] exp_q[$];
        repeat (3) step();
        reset = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_port_in", port_in, 0);
        chk("rst_out_valid", out_valid, 0);

        // Single word, plus two back-to-back words into the GAP=0 instance
        clear_rec();
        push = 1; push_data = 16'd10; push2 = 1; push_data2 = 16'h11;
        step();
        push = 0; push_data2 = 16'h22;
        step();
        push2 = 0;
        repeat (30) step();
        chk("one_rises", rise_t.size(), 1);
        chk("one_len", (plen.size() > 0) ? plen[0] : -1, 10);
        chk("one_data", (rise_d.size() > 0) ? rise_d[0] : 16'hffff, 10);
        chk("one_idle", busy, 0);
        chk("gap0_rises", rise2_t.size(), 2);
        if (rise2_t.size() == 2) begin
            chk("gap0_spacing", rise2_t[1] - rise2_t[0], 4);
            chk("gap0_data1", rise2_d[1], 16'h22);
        end

        // Fill behind a busy transmitter: 10,5,7,3 fill the FIFO, 9 is dropped
        clear_rec();
        exp_q = '{16'd1, 16'd10, 16'd5, 16'd7, 16'd3};
        push = 1;
        foreach (exp_q[i]) begin
            push_data = exp_q[i];
            step();
        end
        chk("fill_full", full, 1);
        push_data = 16'd9;
        step();
        push = 0;
        chk("drop_full", full, 1);
        repeat (5 * 27 + 10) step();
        chk("burst_rises", rise_t.size(), 5);
        if (rise_t.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("burst_data", rise_d[i], exp_q[i]);
            for (int i = 1; i < 5; i++) chk("burst_spacing", rise_t[i] - rise_t[i-1], 27);
            foreach (plen[i]) chk("burst_len", plen[i], 10);
        end
        chk("burst_empty", empty, 1);

        // Monitor: change, ack, hold, change+ack, unacknowledged change
        port_out = 16'd15;
        step();
        chk("mon_valid", out_valid, 1);
        chk("mon_data", out_data, 15);
        out_ack = 1;
        step();
        out_ack = 0;
        chk("mon_ack", out_valid, 0);
        repeat (3) step();
        chk("mon_hold", out_valid, 0);
        port_out = 16'd20; out_ack = 1;
        step();
        out_ack = 0;
        chk("mon_race_valid", out_valid, 1);
        chk("mon_race_data", out_data, 20);
        port_out = 16'd25;
        step();
        chk("mon_over_data", out_data, 25);
`ifdef PORT_HOST_OVERRUN_EN
        chk("mon_overrun", overrun, 1);
`endif
        out_ack = 1;
        step();
        out_ack = 0;

        // Reset during the fifth pulse cycle with two words queued
        push = 1; push_data = 16'd30;
        step();
        push_data = 16'd31;
        step();
        push_data = 16'd32;
        step();
        push = 0;
        chk("pre_rst_pw", port_write, 1);
        repeat (2) step();
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_pw", port_write, 0);
        chk("mid_rst_port_in", port_in, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_busy", busy, 0);
        n = rise_t.size();
        repeat (40) step();
        chk("mid_rst_silent", rise_t.size(), n);

        // Random traffic: heavy push rate first (drops), then sparse
        for (int i = 0; i < 2400; i++) begin
            push = (i < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            push_data = 16'($urandom);
            if ($urandom_range(0, 2) == 0) port_out = 16'($urandom_range(0, 7));
            out_ack = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        push = 0; out_ack = 0; reset = 0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
